// File: rtl/board_stream_printer.sv
// Snapshots a ROWS x COLS grid of unsigned cells and streams it as right-aligned
// decimal ASCII text (space-separated, CR/LF per row) over a valid/ready byte port.
module board_stream_printer #(
   parameter int unsigned ROWS   = 4,
   parameter int unsigned COLS   = 4,
   parameter int unsigned CELL_W = 20,
   parameter int unsigned DIGITS = 7
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [ROWS*COLS*CELL_W-1:0]   board,
   input  logic                          tx_ready,
   output logic [7:0]                    char_out,
   output logic                          char_valid,
   output logic                          busy,
   output logic                          done
);

   localparam int unsigned CELLS   = ROWS * COLS;
   localparam int unsigned BOARD_W = CELLS * CELL_W;
   localparam int unsigned BCD_W   = 4 * DIGITS;
   localparam int unsigned DD_W    = BCD_W + CELL_W;
   localparam int unsigned IDX_W   = (CELLS  > 1) ? $clog2(CELLS)  : 1;
   localparam int unsigned COL_W   = (COLS   > 1) ? $clog2(COLS)   : 1;
   localparam int unsigned ROW_W   = (ROWS   > 1) ? $clog2(ROWS)   : 1;
   localparam int unsigned DIG_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned CNT_W   = (CELL_W > 1) ? $clog2(CELL_W) : 1;

   // True when DIGITS decimal places can hold every CELL_W-bit value.
   function automatic bit digits_fit();
      logic [511:0] p10;
      logic [511:0] p2;
      p10 = 512'd1;
      p2  = 512'd1;
      for (int unsigned i = 0; i < DIGITS; i++) p10 = (p10 << 3) + (p10 << 1);
      for (int unsigned i = 0; i < CELL_W; i++) p2 = p2 << 1;
      return p10 > p2;
   endfunction

   localparam bit FITS = digits_fit();

   generate
      if (!FITS) begin : g_param_check
         $fatal(1, "board_stream_printer: DIGITS too small for CELL_W");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE,
      S_CONV,
      S_EMIT_DIGIT,
      S_EMIT_SEP,
      S_EMIT_CR,
      S_EMIT_LF,
      S_DONE
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [BOARD_W-1:0] r_snap;
   logic [CELL_W-1:0]  r_shift;
   logic [BCD_W-1:0]   r_bcd;
   logic [CNT_W-1:0]   r_bitcnt;
   logic [DIG_W-1:0]   r_dig;
   logic               r_seen;
   logic [IDX_W-1:0]   r_idx;
   logic [COL_W-1:0]   r_col;
   logic [ROW_W-1:0]   r_row;

   logic               w_fire;
   logic               w_last_bit;
   logic               w_last_dig;
   logic               w_last_col;
   logic               w_last_row;
   logic [BCD_W-1:0]   w_adj;
   logic [DD_W-1:0]    w_dd_nxt;
   logic [3:0]         w_nib;
   logic [7:0]         w_digit_char;
   logic [IDX_W-1:0]   w_nidx;
   logic [CELL_W-1:0]  w_ncell;

   assign w_fire     = char_valid && tx_ready;
   assign w_last_bit = (r_bitcnt == CNT_W'(CELL_W - 1));
   assign w_last_dig = (r_dig == '0);
   assign w_last_col = (r_col == COL_W'(COLS - 1));
   assign w_last_row = (r_row == ROW_W'(ROWS - 1));
   assign w_nidx     = r_idx + 1'b1;

   // Double-dabble step: add 3 to every nibble >= 5, then shift the next bit in.
   always_comb begin
      w_adj = r_bcd;
      for (int unsigned n = 0; n < DIGITS; n++) begin
         if (w_adj[n*4 +: 4] >= 4'd5) w_adj[n*4 +: 4] = w_adj[n*4 +: 4] + 4'd3;
      end
      w_dd_nxt = {w_adj, r_shift} << 1;
   end

   always_comb begin
      w_ncell = '0;
      for (int unsigned k = 0; k < CELLS; k++) begin
         if (IDX_W'(k) == w_nidx) w_ncell = r_snap[k*CELL_W +: CELL_W];
      end
   end

   // Leading zeros are blanked; an all-zero cell shows '.' in its last column.
   always_comb begin
      w_nib = '0;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (DIG_W'(d) == r_dig) w_nib = r_bcd[d*4 +: 4];
      end
      if (w_nib != 4'd0 || r_seen) w_digit_char = {4'h3, w_nib};
      else if (w_last_dig)         w_digit_char = 8'h2E;
      else                         w_digit_char = 8'h20;
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:       if (start) w_state_nxt = S_CONV;
         S_CONV:       if (w_last_bit) w_state_nxt = S_EMIT_DIGIT;
         S_EMIT_DIGIT: if (w_fire && w_last_dig) w_state_nxt = w_last_col ? S_EMIT_CR : S_EMIT_SEP;
         S_EMIT_SEP:   if (w_fire) w_state_nxt = S_CONV;
         S_EMIT_CR:    if (w_fire) w_state_nxt = S_EMIT_LF;
         S_EMIT_LF:    if (w_fire) w_state_nxt = w_last_row ? S_DONE : S_CONV;
         S_DONE:       w_state_nxt = S_IDLE;
         default:      w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      char_out   = '0;
      char_valid = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (r_state)
         S_CONV:       busy = 1'b1;
         S_EMIT_DIGIT: begin busy = 1'b1; char_valid = 1'b1; char_out = w_digit_char; end
         S_EMIT_SEP:   begin busy = 1'b1; char_valid = 1'b1; char_out = 8'h20; end
         S_EMIT_CR:    begin busy = 1'b1; char_valid = 1'b1; char_out = 8'h0D; end
         S_EMIT_LF:    begin busy = 1'b1; char_valid = 1'b1; char_out = 8'h0A; end
         S_DONE:       done = 1'b1;
         default:      ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_snap   <= '0;
         r_shift  <= '0;
         r_bcd    <= '0;
         r_bitcnt <= '0;
         r_dig    <= '0;
         r_seen   <= 1'b0;
         r_idx    <= '0;
         r_col    <= '0;
         r_row    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_snap   <= board;
                  r_shift  <= board[CELL_W-1:0];
                  r_bcd    <= '0;
                  r_bitcnt <= '0;
                  r_idx    <= '0;
                  r_col    <= '0;
                  r_row    <= '0;
               end
            end
            S_CONV: begin
               {r_bcd, r_shift} <= w_dd_nxt;
               r_bitcnt         <= r_bitcnt + 1'b1;
               if (w_last_bit) begin
                  r_dig  <= DIG_W'(DIGITS - 1);
                  r_seen <= 1'b0;
               end
            end
            S_EMIT_DIGIT: begin
               if (w_fire) begin
                  if (w_nib != 4'd0) r_seen <= 1'b1;
                  r_dig <= r_dig - 1'b1;
               end
            end
            S_EMIT_SEP: begin
               if (w_fire) begin
                  r_idx    <= w_nidx;
                  r_col    <= r_col + 1'b1;
                  r_shift  <= w_ncell;
                  r_bcd    <= '0;
                  r_bitcnt <= '0;
               end
            end
            S_EMIT_LF: begin
               if (w_fire && !w_last_row) begin
                  r_idx    <= w_nidx;
                  r_col    <= '0;
                  r_row    <= r_row + 1'b1;
                  r_shift  <= w_ncell;
                  r_bcd    <= '0;
                  r_bitcnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_board_stream_printer.sv
// Directed bench for board_stream_printer: expected text is generated from a
// decimal model into a byte queue and compared as bytes are handed off.
module tb_board_stream_printer;

   localparam int ROWS   = 4;
   localparam int COLS   = 4;
   localparam int CELL_W = 20;
   localparam int DIGITS = 7;
   localparam int BW     = ROWS * COLS * CELL_W;
   localparam int NBYTES = ROWS * (COLS * DIGITS + COLS - 1 + 2);

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          tx_ready;
   logic [BW-1:0] board;
   logic [7:0]    char_out;
   logic          char_valid;
   logic          busy;
   logic          done;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [7:0]    exp_q[$];

   board_stream_printer #(
      .ROWS   (ROWS),
      .COLS   (COLS),
      .CELL_W (CELL_W),
      .DIGITS (DIGITS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .board      (board),
      .tx_ready   (tx_ready),
      .char_out   (char_out),
      .char_valid (char_valid),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Decimal model: divide by powers of ten, blank leading zeros.
   task automatic push_expected(input logic [BW-1:0] b);
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            int unsigned v;
            v = 32'(b[(r*COLS+c)*CELL_W +: CELL_W]);
            for (int k = 0; k < DIGITS; k++) begin
               int unsigned pw;
               pw = 1;
               for (int j = 0; j < DIGITS - 1 - k; j++) pw = pw * 10;
               if (v == 0)       exp_q.push_back((k == DIGITS - 1) ? 8'h2E : 8'h20);
               else if (v >= pw) exp_q.push_back(8'(32'h30 + (v / pw) % 10));
               else              exp_q.push_back(8'h20);
            end
            if (c < COLS - 1) exp_q.push_back(8'h20);
         end
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
      end
   endtask

   function automatic logic [BW-1:0] rand_board();
      logic [BW-1:0] b;
      int unsigned   v;
      b = '0;
      for (int i = 0; i < ROWS * COLS; i++) begin
         case (i % 4)
            0:       v = $urandom_range(0, 9);
            1:       v = $urandom_range(100, 99999);
            2:       v = (i == 6) ? 0 : $urandom_range(0, 1048575);
            default: v = $urandom_range(1000000, 1048575);
         endcase
         b[i*CELL_W +: CELL_W] = CELL_W'(v);
      end
      return b;
   endfunction

   task automatic start_print(input logic [BW-1:0] b);
      int lat;
      lat   = 0;
      board = b;
      push_expected(b);
      @(negedge clk);
      tx_ready = 1'b0;
      start    = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         start = 1'b0;
         lat++;
         if (lat == 1) check("busy_after_start", 32'(busy), 1);
         if (char_valid) break;
      end
      check("first_valid_latency", 32'(lat), CELL_W + 1);
   endtask

   // mode 0: ready always high; 1: random ready; 2: random ready plus a 50-cycle
   // stall mid-digit, board change and a stray start while busy.
   task automatic consume(input int mode, input int limit, input bit start_at_done);
      int         popped;
      int         ndone;
      int         cyc;
      int         gap;
      int         hold_left;
      bit         hold_started;
      bit         stall;
      bit         finished;
      logic [7:0] held;
      logic [7:0] e;
      popped = 0; ndone = 0; cyc = 0; gap = 0; hold_left = 0;
      hold_started = 1'b0; stall = 1'b0; finished = 1'b0; held = '0;
      while (!finished && cyc < 6000) begin
         @(negedge clk);
         cyc++;
         if (stall) begin
            check("valid_held", 32'(char_valid), 1);
            check("char_held", 32'(char_out), 32'(held));
         end
         if (hold_left > 0) begin
            tx_ready = 1'b0;
            hold_left--;
         end else if (mode == 2 && !hold_started && popped == 10) begin
            hold_started = 1'b1;
            hold_left    = 49;
            tx_ready     = 1'b0;
         end else begin
            tx_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         end
         if (mode == 2 && cyc == 30) board = ~board;
         if (mode == 2) start = (cyc == 40);
         if (!char_valid && busy) gap++;
         else if (char_valid && gap > 0) begin
            check("conv_gap", 32'(gap), CELL_W);
            gap = 0;
         end
         if (char_valid && tx_ready) begin
            if (exp_q.size() == 0) check("queue_underflow", 32'(exp_q.size()), 1);
            else begin
               e = exp_q.pop_front();
               check($sformatf("byte%0d", popped), 32'(char_out), 32'(e));
            end
            popped++;
            if (popped == limit) finished = 1'b1;
         end
         stall = char_valid && !tx_ready;
         held  = char_out;
         if (done) begin
            ndone++;
            check("busy_at_done", 32'(busy), 0);
            check("valid_at_done", 32'(char_valid), 0);
            finished = 1'b1;
            if (start_at_done) start = 1'b1;
         end
      end
      check("consume_timeout", 32'(finished), 1);
      if (limit == 0) begin
         check("done_count", 32'(ndone), 1);
         check("byte_count", 32'(popped), NBYTES);
         check("queue_empty", 32'(exp_q.size()), 0);
         @(negedge clk);
         start = 1'b0;
         check("done_one_cycle", 32'(done), 0);
         check("idle_after_done", 32'(busy), 0);
         @(negedge clk);
         check("no_restart", 32'(busy), 0);
      end
   endtask

   initial begin
      logic [BW-1:0] b;
      rst = 1'b1; start = 1'b0; tx_ready = 1'b0; board = '0;
      repeat (3) @(negedge clk);
      check("rst_char_out", 32'(char_out), 0);
      check("rst_valid", 32'(char_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_busy", 32'(busy), 0);

      // All-zero board, sink always ready.
      start_print('0);
      consume(0, 0, 1'b0);

      // Cell 0 = 2048.
      b = '0;
      b[CELL_W-1:0] = CELL_W'(2048);
      start_print(b);
      consume(0, 0, 1'b0);

      // Maximum value in the last cell, random ready.
      b = rand_board();
      b[15*CELL_W +: CELL_W] = CELL_W'(1048575);
      start_print(b);
      consume(1, 0, 1'b0);

      // Backpressure, snapshot immunity, start while busy and at done.
      b = rand_board();
      start_print(b);
      consume(2, 0, 1'b1);

      // Reset mid-row, then a clean print from cell 0.
      b = rand_board();
      start_print(b);
      consume(1, 12, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      tx_ready = 1'b1;
      @(negedge clk);
      check("midrst_valid", 32'(char_valid), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_done", 32'(done), 0);
      check("midrst_char", 32'(char_out), 0);
      rst = 1'b0;
      exp_q.delete();
      b = rand_board();
      start_print(b);
      consume(0, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
